// File: rtl/regfile_pkg.sv
// Shared widths, forwarding-select and write-enable helpers for the
// forwarding register file family.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_NUM_WR = 2;
  localparam int DEF_NUM_RD = 2;

  // Helpers work on vectors padded to these limits so one function serves every instance.
  localparam int MAX_WR     = 16;
  localparam int MAX_ADDR_W = 16;
  localparam int SEL_W      = 4;

  typedef struct packed {
    logic             hit;
    logic [SEL_W-1:0] port;
  } fwd_sel_t;

  // Later ports override earlier ones, so the highest-index match is returned.
  function automatic fwd_sel_t rf_fwd_sel(
    input logic [MAX_WR-1:0]            we_eff,
    input logic [MAX_WR*MAX_ADDR_W-1:0] waddr,
    input logic [MAX_ADDR_W-1:0]        raddr
  );
    fwd_sel_t sel;
    sel = '0;
    for (int k = 0; k < MAX_WR; k++) begin
      if (we_eff[k] && (waddr[k*MAX_ADDR_W +: MAX_ADDR_W] == raddr)) begin
        sel.hit  = 1'b1;
        sel.port = SEL_W'(k);
      end
    end
    return sel;
  endfunction

  function automatic logic rf_eff_we(
    input logic we,
    input logic addr_is_zero,
    input logic zero_r0
  );
    return we && !(zero_r0 && addr_is_zero);
  endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// One read port: picks forwarded write data over the stored value and
// reports whether the result is current.
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_WR  = DEF_NUM_WR,
  parameter int ZERO_R0 = 0
) (
  input  logic [NUM_WR-1:0]        we_eff,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic                     pend_bit,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid
);

  localparam logic ZR0 = (ZERO_R0 != 0);

  logic [MAX_WR-1:0]            we_pad;
  logic [MAX_WR*MAX_ADDR_W-1:0] waddr_pad;
  logic [MAX_ADDR_W-1:0]        raddr_pad;
  fwd_sel_t                     sel;
  logic [DATA_W-1:0]            fwd_data;
  logic                         is_r0;

  always_comb begin
    we_pad    = '0;
    waddr_pad = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      we_pad[k] = we_eff[k];
      waddr_pad[k*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(waddr[k*ADDR_W +: ADDR_W]);
    end
    raddr_pad = MAX_ADDR_W'(raddr);
  end

  assign sel = rf_fwd_sel(we_pad, waddr_pad, raddr_pad);

  always_comb begin
    fwd_data = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (sel.port == SEL_W'(k)) fwd_data = wdata[k*DATA_W +: DATA_W];
    end
  end

  assign is_r0 = ZR0 && (raddr == '0);

  // A hardwired R0 is always current and never forwarded.
  always_comb begin
    if (is_r0) begin
      rdata  = '0;
      rvalid = 1'b1;
    end else if (sel.hit) begin
      rdata  = fwd_data;
      rvalid = 1'b1;
    end else begin
      rdata  = reg_data;
      rvalid = !pend_bit;
    end
  end

endmodule

// File: rtl/regfile_fwd_sb.sv
// Multi-port register file with write-to-read forwarding, a pending
// scoreboard for issued producers and a same-address write conflict flag.
module regfile_fwd_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_WR  = DEF_NUM_WR,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [2**ADDR_W-1:0]     pending,
  output logic                     wr_conflict
);

  localparam int   NREG = 2**ADDR_W;
  localparam logic ZR0  = (ZERO_R0 != 0);

  logic [DATA_W-1:0] regs [NREG];
  logic [NUM_WR-1:0] we_eff;
  logic [NREG-1:0]   pend_nxt;
  logic              conflict_nxt;

  always_comb begin
    we_eff = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      we_eff[k] = rf_eff_we(we[k], waddr[k*ADDR_W +: ADDR_W] == '0, ZR0);
    end
  end

  // Writes are applied in port order so the highest-index port lands last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we_eff[k]) regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Reserve is applied after the clears: a freshly issued producer outranks a retiring one.
  always_comb begin
    pend_nxt = pending;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we_eff[k]) pend_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (rsv_en && !(ZR0 && (rsv_addr == '0))) pend_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    conflict_nxt = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (we_eff[i] && we_eff[j] &&
            (waddr[i*ADDR_W +: ADDR_W] == waddr[j*ADDR_W +: ADDR_W]))
          conflict_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      pending     <= pend_nxt;
      wr_conflict <= conflict_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] reg_data;

    assign ra       = raddr[i*ADDR_W +: ADDR_W];
    assign reg_data = regs[ra];

    regfile_fwd_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_R0 (ZERO_R0)
    ) u_mux (
      .we_eff   (we_eff),
      .waddr    (waddr),
      .wdata    (wdata),
      .reg_data (reg_data),
      .raddr    (ra),
      .pend_bit (pending[ra]),
      .rdata    (rdata[i*DATA_W +: DATA_W]),
      .rvalid   (rvalid[i])
    );
  end

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Self-checking bench: directed vector table, reset and hardwired-R0 sequences,
// then random traffic against an array-based reference model.
module tb_regfile_fwd_sb;

  logic        clk, rst;
  logic [1:0]  we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic [5:0]  raddr;
  logic [31:0] rdata;
  logic [1:0]  rvalid;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic [7:0]  pending;
  logic        wr_conflict;

  logic [1:0]  z_we;
  logic [5:0]  z_waddr;
  logic [31:0] z_wdata;
  logic [5:0]  z_raddr;
  logic [31:0] z_rdata;
  logic [1:0]  z_rvalid;
  logic        z_rsv_en;
  logic [2:0]  z_rsv_addr;
  logic [7:0]  z_pending;
  logic        z_wr_conflict;

  regfile_fwd_sb #(.DATA_W(16), .ADDR_W(3), .NUM_WR(2), .NUM_RD(2), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata), .rvalid(rvalid), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pending(pending), .wr_conflict(wr_conflict)
  );

  regfile_fwd_sb #(.DATA_W(16), .ADDR_W(3), .NUM_WR(2), .NUM_RD(2), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst), .we(z_we), .waddr(z_waddr), .wdata(z_wdata), .raddr(z_raddr),
    .rdata(z_rdata), .rvalid(z_rvalid), .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr),
    .pending(z_pending), .wr_conflict(z_wr_conflict)
  );

  typedef struct {
    logic [1:0]  w;
    logic [2:0]  a0, a1;
    logic [15:0] d0, d1;
    logic [2:0]  r0, r1;
    logic        rs;
    logic [2:0]  ra;
    logic [15:0] erd0, erd1;
    logic [1:0]  erv;
    logic [7:0]  epend;
    logic        econf;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int n_cmp, n_fail;

  logic [15:0] m_regs [8];
  logic [7:0]  m_pend;
  logic        m_conf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] w, input logic [2:0] a0, input logic [2:0] a1,
                               input logic [15:0] d0, input logic [15:0] d1,
                               input logic [2:0] r0, input logic [2:0] r1,
                               input logic rs, input logic [2:0] ra);
    we       = w;
    waddr    = {a1, a0};
    wdata    = {d1, d0};
    raddr    = {r1, r0};
    rsv_en   = rs;
    rsv_addr = ra;
  endtask

  // Reference read: latest write this cycle wins, else stored value; valid unless stale.
  function automatic logic [16:0] modelRead(input logic [2:0] ra);
    logic        hit;
    logic [15:0] d;
    hit = 1'b0;
    d   = m_regs[ra];
    for (int k = 0; k < 2; k++) begin
      if (we[k] && (waddr[k*3 +: 3] == ra)) begin
        hit = 1'b1;
        d   = wdata[k*16 +: 16];
      end
    end
    return {hit || !m_pend[ra], d};
  endfunction

  task automatic modelEdge();
    for (int k = 0; k < 2; k++) if (we[k]) m_regs[waddr[k*3 +: 3]] = wdata[k*16 +: 16];
    for (int k = 0; k < 2; k++) if (we[k]) m_pend[waddr[k*3 +: 3]] = 1'b0;
    if (rsv_en) m_pend[rsv_addr] = 1'b1;
    m_conf = (we == 2'b11) && (waddr[2:0] == waddr[5:3]);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_pend = '0;
    m_conf = 1'b0;
  endtask

  initial begin
    logic [16:0] exp_rd;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    applyStimulus(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
    z_we = '0; z_waddr = '0; z_wdata = '0; z_raddr = '0; z_rsv_en = 1'b0; z_rsv_addr = '0;
    modelReset();

    //            w      a0    a1    d0        d1        r0    r1    rs    ra    erd0      erd1      erv    epend  econf
    vecs[0]  = '{2'b01, 3'd1, 3'd0, 16'hAAAA, 16'h0000, 3'd1, 3'd0, 1'b0, 3'd0, 16'hAAAA, 16'h0000, 2'b11, 8'h00, 1'b0};
    vecs[1]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd1, 3'd1, 1'b0, 3'd0, 16'hAAAA, 16'hAAAA, 2'b11, 8'h00, 1'b0};
    vecs[2]  = '{2'b11, 3'd3, 3'd3, 16'h1234, 16'h5678, 3'd3, 3'd3, 1'b0, 3'd0, 16'h5678, 16'h5678, 2'b11, 8'h00, 1'b1};
    vecs[3]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd3, 3'd3, 1'b0, 3'd0, 16'h5678, 16'h5678, 2'b11, 8'h00, 1'b0};
    vecs[4]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd2, 3'd2, 1'b1, 3'd2, 16'h0000, 16'h0000, 2'b11, 8'h04, 1'b0};
    vecs[5]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd1, 3'd2, 1'b0, 3'd0, 16'hAAAA, 16'h0000, 2'b01, 8'h04, 1'b0};
    vecs[6]  = '{2'b10, 3'd0, 3'd2, 16'h0000, 16'hBBBB, 3'd2, 3'd2, 1'b0, 3'd0, 16'hBBBB, 16'hBBBB, 2'b11, 8'h00, 1'b0};
    vecs[7]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd2, 3'd2, 1'b0, 3'd0, 16'hBBBB, 16'hBBBB, 2'b11, 8'h00, 1'b0};
    vecs[8]  = '{2'b01, 3'd4, 3'd0, 16'h4444, 16'h0000, 3'd4, 3'd4, 1'b1, 3'd4, 16'h4444, 16'h4444, 2'b11, 8'h10, 1'b0};
    vecs[9]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd4, 3'd4, 1'b0, 3'd0, 16'h4444, 16'h4444, 2'b00, 8'h10, 1'b0};
    vecs[10] = '{2'b11, 3'd5, 3'd6, 16'h1111, 16'h6666, 3'd5, 3'd6, 1'b0, 3'd0, 16'h1111, 16'h6666, 2'b11, 8'h10, 1'b0};
    vecs[11] = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd5, 3'd4, 1'b1, 3'd5, 16'h1111, 16'h4444, 2'b01, 8'h30, 1'b0};
    vecs[12] = '{2'b11, 3'd7, 3'd7, 16'h7070, 16'h7171, 3'd7, 3'd5, 1'b0, 3'd0, 16'h7171, 16'h1111, 2'b01, 8'h30, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst.pending", 32'(pending), 32'h0);
    checkOutput("rst.wr_conflict", 32'(wr_conflict), 32'h0);
    checkOutput("rst.rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].w, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1,
                    vecs[i].r0, vecs[i].r1, vecs[i].rs, vecs[i].ra);
      #1;
      checkOutput($sformatf("v%0d.rdata0", i), 32'(rdata[15:0]),  32'(vecs[i].erd0));
      checkOutput($sformatf("v%0d.rdata1", i), 32'(rdata[31:16]), 32'(vecs[i].erd1));
      checkOutput($sformatf("v%0d.rvalid", i), 32'(rvalid),       32'(vecs[i].erv));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.pending", i),     32'(pending),     32'(vecs[i].epend));
      checkOutput($sformatf("v%0d.wr_conflict", i), 32'(wr_conflict), 32'(vecs[i].econf));
      @(negedge clk);
    end

    // Reset lands while R5 is written and reserved and a conflict is flagged.
    $display("[TB] asynchronous reset mid-run");
    applyStimulus(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 3'd5, 3'd1, 1'b0, 3'd0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst.rdata0", 32'(rdata[15:0]),  32'h0);
    checkOutput("midrst.rdata1", 32'(rdata[31:16]), 32'h0);
    checkOutput("midrst.pending", 32'(pending), 32'h0);
    checkOutput("midrst.wr_conflict", 32'(wr_conflict), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] hardwired R0 instance");
    z_we = 2'b11; z_waddr = {3'd0, 3'd0}; z_wdata = {16'hFFFF, 16'hFFFF};
    z_raddr = {3'd0, 3'd0}; z_rsv_en = 1'b1; z_rsv_addr = 3'd0;
    #1;
    checkOutput("z0.rdata", z_rdata, 32'h0);
    checkOutput("z0.rvalid", 32'(z_rvalid), 32'h3);
    @(posedge clk);
    #1;
    checkOutput("z0.pending", 32'(z_pending), 32'h0);
    checkOutput("z0.wr_conflict", 32'(z_wr_conflict), 32'h0);
    @(negedge clk);
    z_we = 2'b10; z_waddr = {3'd1, 3'd0}; z_wdata = {16'h1357, 16'hFFFF};
    z_raddr = {3'd1, 3'd0}; z_rsv_en = 1'b0;
    #1;
    checkOutput("z1.rdata", z_rdata, {16'h1357, 16'h0000});
    checkOutput("z1.rvalid", 32'(z_rvalid), 32'h3);
    @(negedge clk);
    z_we = 2'b00; z_raddr = {3'd0, 3'd1};
    #1;
    checkOutput("z2.rdata", z_rdata, {16'h0000, 16'h1357});
    checkOutput("z2.pending", 32'(z_pending), 32'h0);

    $display("[TB] random traffic against reference model");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int c = 0; c < 400; c++) begin
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
      #1;
      for (int p = 0; p < 2; p++) begin
        exp_rd = modelRead(raddr[p*3 +: 3]);
        checkOutput($sformatf("rnd%0d.rdata%0d", c, p), 32'(rdata[p*16 +: 16]), 32'(exp_rd[15:0]));
        checkOutput($sformatf("rnd%0d.rvalid%0d", c, p), 32'(rvalid[p]), 32'(exp_rd[16]));
      end
      @(posedge clk);
      #1;
      modelEdge();
      checkOutput($sformatf("rnd%0d.pending", c), 32'(pending), 32'(m_pend));
      checkOutput($sformatf("rnd%0d.wr_conflict", c), 32'(wr_conflict), 32'(m_conf));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_fwd_sb.md
# regfile_fwd_sb

Parametrised multi-port register file with same-cycle write-to-read forwarding, a per-register pending scoreboard and an optional hardwired-zero R0. It is the next generation of the team's two-write/two-read forwarding register file. It sits in the datapath decode stage, where issue logic reserves destination registers and writeback ports retire them.

## Interface
- `DATA_W`, 16: register width in bits.
- `ADDR_W`, 3: address width; depth `NREG = 2**ADDR_W`.
- `NUM_WR`, 2: number of write ports (≥1).
- `NUM_RD`, 2: number of read ports (≥1).
- `ZERO_R0`, 0: when 1, R0 reads as zero and is never written, reserved or forwarded.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we`  in  NUM_WR  per-port write enable.
- `waddr`  in  NUM_WR*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- `wdata`  in  NUM_WR*DATA_W  write data, packed the same way.
- `raddr`  in  NUM_RD*ADDR_W  read addresses.
- `rdata`  out  NUM_RD*DATA_W  read data, combinational.
- `rvalid`  out  NUM_RD  1 when read data is not stale (see Operation).
- `rsv_en`  in  1  reserve request: mark `rsv_addr` pending.
- `rsv_addr`  in  ADDR_W  register being reserved.
- `pending`  out  NREG  scoreboard bits, registered.
- `wr_conflict`  out  1  registered pulse flagging a multi-port write to one address.

## Operation
- **Effective write.** Port k writes when `we[k]` is set and the write is not to R0 with `ZERO_R0=1`.
- **Write.** At the rising edge, every effective write updates `regs[waddr_k]`. If several ports target the same address, the highest-index port wins.
- **Read.** `rdata_i` is the highest-index effective write with `waddr == raddr_i` in the current cycle (forwarding). With no such write, `rdata_i = regs[raddr_i]`. With `ZERO_R0=1` and `raddr_i == 0`, `rdata_i = 0`.
- **rvalid.** `rvalid_i = forward_hit_i | ~pending[raddr_i]`. It is forced to 1 for R0 when `ZERO_R0=1`.
- **Scoreboard update at each edge:**
  - An effective write to address a clears `pending[a]`.
  - `rsv_en` sets `pending[rsv_addr]`, except R0 when `ZERO_R0=1`.
  - Reserve and write to the same address in the same cycle: reserve wins, so the bit ends at 1 (a new producer has been issued).
  - Writes to non-pending registers are legal and leave the bit 0.
- **Conflict flag.** `wr_conflict` is set at the edge after any cycle in which two or more effective writes share an address. It is 0 after any other cycle.

## Timing
- **Reset.** Asynchronous; all `regs` = 0, `pending` = 0, `wr_conflict` = 0 while `rst` is high. Reset release is synchronised by the surrounding design.
- **Read path** is zero-latency combinational: from `raddr`, `we`, `waddr`, `wdata` and `pending` to `rdata`/`rvalid`.
- **Latencies:**
  - Register contents become visible without forwarding 1 cycle after the write edge.
  - `pending` changes 1 cycle after `rsv_en` or the write.
  - `wr_conflict` asserts 1 cycle after the offending cycle and lasts 1 cycle per offending cycle.
- **Reset mid-operation** drops all pending bits and contents immediately. In-flight writes in that cycle are lost.
- **Address range.** No out-of-range case exists: the address is exactly ADDR_W bits.

## Structure
- **Shared package `regfile_pkg`:**
  - Default widths.
  - Function `rf_fwd_sel` returning the highest-index matching write port plus a hit flag.
  - Function `rf_eff_we` applying the R0 masking.
- **Sub-module `regfile_fwd_mux`:** one read port's forwarding mux, instantiated NUM_RD times via generate. Its inputs are the write-port vectors, the register-array read value, `raddr` and the `pending` bit. Its outputs are `rdata` and `rvalid`.
- **Top level** holds the register array, the scoreboard register and the conflict detector.

## Test plan
All scenarios use the defaults DATA_W=16, ADDR_W=3, NUM_WR=2, NUM_RD=2.

- **Reset:** assert `rst` mid-run after writing R5=0x1111 and reserving R5. All `rdata` read 0x0000, `pending` = 0x00, `wr_conflict` = 0.
- **Same-cycle forwarding:** `we[0]=1`, R1←0xAAAA, `raddr0=1`. `rdata0`=0xAAAA in that cycle; still 0xAAAA next cycle with `we=0`.
- **Dual write, same address:** port0 R3←0x1234, port1 R3←0x5678, both reads on R3.
  - Both `rdata` = 0x5678 in that cycle and after.
  - `wr_conflict`=1 for exactly one cycle.
- **Scoreboard:**
  - Reserve R2 → `pending[2]`=1 and `rvalid1`=0 on `raddr1=2`.
  - Port1 writes R2←0xBBBB → `rvalid1`=1 and `rdata1`=0xBBBB that cycle; `pending[2]`=0 next cycle.
  - Reserve plus write to R4 in one cycle → `pending[4]` ends at 1.
- **ZERO_R0=1 instance:** write 0xFFFF to R0 and reserve R0 → reads 0x0000, `rvalid`=1, `pending[0]`=0, no `wr_conflict` even when both ports write R0.
